dcache_ctrl: RTL and testbench



---
 rtl/dcache_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Load/store hits complete combinationally in the request cycle. A miss holds
// p1_stall_o while the controller optionally writes the dirty victim line back,
// fetches the requested line, and installs it. The request then hits, and a
// held store merges as an ordinary write hit.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   p1_req_i           CPU access valid
//   p1_write_i         1 = store, 0 = load
//   p1_addr_i          byte address
//   p1_data_i          store data
//   p1_data_o          load data (0 when not hitting)
//   p1_stall_o         CPU must hold the request and freeze
//   mem_enable_o       memory request valid (registered)
//   mem_write_o        1 = line writeback, 0 = line fetch
//   mem_addr_o         line-aligned memory address
//   mem_data_o         writeback line
//   mem_data_i         fetched line
//   mem_ack_i          single-cycle completion pulse
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int TAG_W     = 32 - $clog2(NUM_LINES) - $clog2(LINE_BITS / 8)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 p1_req_i,
    input  logic                 p1_write_i,
    input  logic [31:0]          p1_addr_i,
    input  logic [31:0]          p1_data_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int OFF_W  = $clog2(LINE_BITS / 8);
    localparam int WORDS  = LINE_BITS / 32;
    localparam int WSEL_W = $clog2(WORDS);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_FETCH     = 2'd2;
    localparam logic [1:0] S_REFILL    = 2'd3;

    // Request address fields
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] req_wsel;
    logic              unused_addr_bits;

    assign req_idx          = p1_addr_i[OFF_W +: IDX_W];
    assign req_tag          = p1_addr_i[31 -: TAG_W];
    assign req_wsel         = p1_addr_i[2 +: WSEL_W];
    assign unused_addr_bits = ^p1_addr_i[1:0];

    // State
    logic [1:0]           state_q, state_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_BITS-1:0] line_buf_q, line_buf_d;
    logic [31:0]          miss_addr_q, miss_addr_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_mem [NUM_LINES];

    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;

    assign fill_idx = miss_addr_q[OFF_W +: IDX_W];
    assign fill_tag = miss_addr_q[31 -: TAG_W];

    // Lookup
    logic             line_busy;
    logic             hit;
    logic             store_we;
    logic             refill_we;
    logic [31:0]      rd_words [WORDS];
    logic [LINE_BITS-1:0] rd_line;

    // While a miss is in flight its index is off limits: the victim has
    // already been snapshotted for writeback and the slot is about to be
    // overwritten, so a hit there would be lost.
    assign line_busy = (state_q != S_IDLE) && (req_idx == fill_idx);
    assign hit       = p1_req_i && !rst_i && valid_q[req_idx] && !line_busy
                       && (tag_mem[req_idx] == req_tag);
    assign store_we  = hit && p1_write_i;
    assign refill_we = (state_q == S_REFILL);

    assign p1_stall_o = p1_req_i && !rst_i && !hit;
    assign p1_data_o  = hit ? rd_words[req_wsel] : 32'h0;

    // Line data, one word-wide array per word slot so a store touches only
    // its own word. Reads are combinational to give same-cycle hits.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        logic [31:0] word_mem [NUM_LINES];

        always_ff @(posedge clk_i) begin
            if (refill_we) begin
                word_mem[fill_idx] <= line_buf_q[gi*32 +: 32];
            end
            if (store_we && (req_wsel == WSEL_W'(gi))) begin
                word_mem[req_idx] <= p1_data_i;
            end
        end

        assign rd_words[gi]          = word_mem[req_idx];
        assign rd_line[gi*32 +: 32]  = word_mem[req_idx];
    end

    always_ff @(posedge clk_i) begin
        if (refill_we) begin
            tag_mem[fill_idx] <= fill_tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (refill_we) begin
                valid_q[fill_idx] <= 1'b1;
                dirty_q[fill_idx] <= 1'b0;
            end
            if (store_we) begin
                dirty_q[req_idx] <= 1'b1;
            end
        end
    end

    // Miss FSM. Memory-side outputs are registered; an ack is only honoured
    // while a request is actually being presented.
    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_buf_d  = line_buf_q;
        miss_addr_d = miss_addr_q;
        case (state_q)
            S_IDLE: begin
                if (p1_req_i && !hit) begin
                    miss_addr_d = {p1_addr_i[31:OFF_W], {OFF_W{1'b0}}};
                    mem_en_d    = 1'b1;
                    if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d     = S_WRITEBACK;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_mem[req_idx], req_idx, {OFF_W{1'b0}}};
                        mem_wdata_d = rd_line;
                    end else begin
                        state_d    = S_FETCH;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {p1_addr_i[31:OFF_W], {OFF_W{1'b0}}};
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_en_q && mem_ack_i) begin
                    // Drop enable for one cycle between writeback and fetch.
                    state_d    = S_FETCH;
                    mem_en_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = miss_addr_q;
                end
            end
            S_FETCH: begin
                if (mem_en_q && mem_ack_i) begin
                    state_d    = S_REFILL;
                    mem_en_d   = 1'b0;
                    line_buf_d = mem_data_i;
                end else begin
                    mem_en_d = 1'b1;
                end
            end
            S_REFILL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= '0;
            miss_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        line_buf_q <= line_buf_d;
    end

    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_ctrl
// Bench for dcache_ctrl. A reference model tracks which line address each
// cache slot holds, its dirty flag and contents, plus the backing memory
// image. From those it predicts hit/miss, the stall length (0, N+3 or 2N+5),
// the memory requests the controller must issue and the load data. A memory
// responder serves requests with a chosen latency N and checks them against
// the predicted request queue. Directed cases come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         p1_req;
    logic         p1_write;
    logic [31:0]  p1_addr;
    logic [31:0]  p1_wdata;
    logic [31:0]  p1_rdata;
    logic         p1_stall;
    logic         mem_enable;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_ack;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .p1_req_i     (p1_req),
        .p1_write_i   (p1_write),
        .p1_addr_i    (p1_addr),
        .p1_data_i    (p1_wdata),
        .p1_data_o    (p1_rdata),
        .p1_stall_o   (p1_stall),
        .mem_enable_o (mem_enable),
        .mem_write_o  (mem_write),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_wdata),
        .mem_data_i   (mem_rdata),
        .mem_ack_i    (mem_ack)
    );

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } mreq_t;

    mreq_t        exp_q[$];
    logic [255:0] bmem [logic [31:0]];   // model's view of memory
    logic [255:0] phys [logic [31:0]];   // what the responder actually holds
    bit           res_valid [32];
    bit           res_dirty [32];
    logic [31:0]  res_line  [32];
    logic [255:0] res_data  [32];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int           resp_n = 1;
    bit           resp_en = 1'b1;
    bit           force_ack = 1'b0;
    int           req_count = 0;
    logic [31:0]  last_wb_addr = 32'h0;
    logic [255:0] last_wb_data = '0;
    logic [31:0]  last_fetch_addr = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = la ^ 32'(32'h0101_0101 * i) ^ 32'hA5A5_0000;
        end
        return l;
    endfunction

    function automatic logic [255:0] bmem_get(input logic [31:0] la);
        if (bmem.exists(la)) return bmem[la];
        return init_line(la);
    endfunction

    function automatic logic [255:0] phys_get(input logic [31:0] la);
        if (phys.exists(la)) return phys[la];
        return init_line(la);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Apply the effect of a miss on the model and queue the memory traffic it
    // must cause. Returns the number of stall cycles.
    task automatic model_miss(input logic [31:0] addr, input int n, output int exp_len);
        int          idx;
        logic [31:0] la;
        idx = int'(addr[9:5]);
        la  = {addr[31:5], 5'b0};
        if (res_valid[idx] && res_dirty[idx]) begin
            exp_q.push_back('{1'b1, res_line[idx], res_data[idx]});
            bmem[res_line[idx]] = res_data[idx];
            exp_len = 2 * n + 5;
        end else begin
            exp_len = n + 3;
        end
        exp_q.push_back('{1'b0, la, 256'h0});
        res_valid[idx] = 1'b1;
        res_dirty[idx] = 1'b0;
        res_line[idx]  = la;
        res_data[idx]  = bmem_get(la);
    endtask

    // One CPU access. Called at posedge+1; returns at posedge+1 after the
    // cycle in which the access completed, request still asserted.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int n, output int stall_cnt, output logic [31:0] rdata);
        int          idx;
        int          wi;
        int          exp_len;
        logic [31:0] la;
        logic [31:0] exp_word;
        idx = int'(addr[9:5]);
        wi  = int'(addr[4:2]);
        la  = {addr[31:5], 5'b0};
        if (res_valid[idx] && res_line[idx] == la) exp_len = 0;
        else model_miss(addr, n, exp_len);
        resp_n   = n;
        p1_req   = 1'b1;
        p1_write = wr;
        p1_addr  = addr;
        p1_wdata = wdata;
        stall_cnt = 0;
        for (int c = 0; c <= exp_len; c++) begin
            @(negedge clk);
            if (p1_stall) stall_cnt++;
            chk($sformatf("stall_cycle%0d_addr%0h", c, addr), 256'(p1_stall), 256'(c < exp_len));
            if (p1_stall !== (c < exp_len)) break;
        end
        for (int k = 0; k < 100 && p1_stall; k++) begin
            @(negedge clk);
            stall_cnt++;
        end
        if (p1_stall) chk("stall_timeout", 256'(p1_stall), 256'(0));
        rdata    = p1_rdata;
        exp_word = res_data[idx][wi*32 +: 32];
        if (!wr) begin
            chk($sformatf("load_data_%0h", addr), 256'(p1_rdata), 256'(exp_word));
        end else begin
            res_data[idx][wi*32 +: 32] = wdata;
            res_dirty[idx] = 1'b1;
        end
        $display("access %s addr=%08h n=%0d stall=%0d data=%08h", wr ? "ST" : "LD",
                 addr, n, stall_cnt, wr ? wdata : p1_rdata);
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks each request N cycles after enable rises.
    initial begin
        int           cnt;
        int           n_cur;
        logic [31:0]  cap_addr;
        bit           cap_wr;
        mreq_t        e;
        cnt       = 0;
        n_cur     = 0;
        cap_addr  = 32'h0;
        cap_wr    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (resp_en && mem_enable && !rst) begin
                if (cnt == 0) begin
                    n_cur    = resp_n;
                    cap_addr = mem_addr;
                    cap_wr   = mem_write;
                    req_count++;
                    if (mem_write) begin
                        last_wb_addr = mem_addr;
                        last_wb_data = mem_wdata;
                    end else begin
                        last_fetch_addr = mem_addr;
                    end
                    if (exp_q.size() == 0) begin
                        chk($sformatf("unexpected_mem_req_%0h", mem_addr), 256'(1), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("mem_write", 256'(mem_write), 256'(e.wr));
                        chk("mem_addr", 256'(mem_addr), 256'(e.addr));
                        if (e.wr) chk("wb_data", mem_wdata, e.data);
                    end
                end
                if (cnt == n_cur) begin
                    chk("mem_addr_hold", 256'(mem_addr), 256'(cap_addr));
                    if (cap_wr) phys[cap_addr] = mem_wdata;
                    else mem_rdata = phys_get(cap_addr);
                    mem_ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                mem_ack = force_ack;
                cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int           sc;
        int           t0;
        int           el;
        logic [31:0]  rd;
        logic [255:0] l40;
        bit           wr;
        logic [31:0]  a;

        rst = 1'b1; p1_req = 1'b0; p1_write = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
        for (int i = 0; i < 32; i++) begin
            res_valid[i] = 1'b0; res_dirty[i] = 1'b0; res_line[i] = 32'h0; res_data[i] = '0;
        end
        l40 = init_line(32'h40);
        l40[31:0] = 32'hDEAD_BEEF;
        bmem[32'h40] = l40;
        phys[32'h40] = l40;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_enable", 256'(mem_enable), 256'(0));
        chk("rst_stall", 256'(p1_stall), 256'(0));
        chk("rst_rdata", 256'(p1_rdata), 256'(0));
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_write", 256'(mem_write), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr), 256'(0));
        chk("rst_mem_data", mem_wdata, 256'(0));
        @(posedge clk); #1;

        // Clean miss, N=4: 7 stall cycles
        access(1'b0, 32'h40, 32'h0, 4, sc, rd);
        chk("t1_stall_len", 256'(sc), 256'(7));
        chk("t1_data", 256'(rd), 256'(32'hDEAD_BEEF));
        chk("t1_fetch_addr", 256'(last_fetch_addr), 256'(32'h40));

        // Store hit, then load it back
        t0 = req_count;
        access(1'b1, 32'h44, 32'h1234_5678, 2, sc, rd);
        chk("t2_store_stall", 256'(sc), 256'(0));
        access(1'b0, 32'h44, 32'h0, 2, sc, rd);
        chk("t2_load_data", 256'(rd), 256'(32'h1234_5678));
        chk("t2_no_mem_traffic", 256'(req_count - t0), 256'(0));

        // Dirty miss, N=3: 11 stall cycles, writeback then fetch
        access(1'b0, 32'h440, 32'h0, 3, sc, rd);
        chk("t3_stall_len", 256'(sc), 256'(11));
        chk("t3_wb_addr", 256'(last_wb_addr), 256'(32'h40));
        chk("t3_wb_word1", 256'(last_wb_data[63:32]), 256'(32'h1234_5678));
        chk("t3_fetch_addr", 256'(last_fetch_addr), 256'(32'h440));

        // Clean eviction of 0x440: one fetch only
        t0 = req_count;
        access(1'b0, 32'h40, 32'h0, 2, sc, rd);
        chk("t4_stall_len", 256'(sc), 256'(5));
        chk("t4_data", 256'(rd), 256'(32'hDEAD_BEEF));
        chk("t4_one_request", 256'(req_count - t0), 256'(1));

        // Back-to-back hits, one per cycle
        t0 = cyc;
        access(1'b0, 32'h40, 32'h0, 1, sc, rd);
        chk("t5_hit0_stall", 256'(sc), 256'(0));
        access(1'b0, 32'h48, 32'h0, 1, sc, rd);
        chk("t5_hit1_stall", 256'(sc), 256'(0));
        access(1'b0, 32'h5C, 32'h0, 1, sc, rd);
        chk("t5_hit2_stall", 256'(sc), 256'(0));
        chk("t5_cycles", 256'(cyc - t0), 256'(3));

        // Reset during FETCH
        @(negedge clk); resp_en = 1'b0;
        @(posedge clk); #1;
        p1_req = 1'b1; p1_write = 1'b0; p1_addr = 32'h1040;
        for (int k = 0; k < 10 && !mem_enable; k++) @(negedge clk);
        chk("t6_fetch_en", 256'(mem_enable), 256'(1));
        chk("t6_fetch_addr", 256'(mem_addr), 256'(32'h1040));
        chk("t6_fetch_wr", 256'(mem_write), 256'(0));
        @(posedge clk); #1; rst = 1'b1; p1_req = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("t6_en_after_rst", 256'(mem_enable), 256'(0));
        chk("t6_stall_after_rst", 256'(p1_stall), 256'(0));
        for (int i = 0; i < 32; i++) begin
            res_valid[i] = 1'b0; res_dirty[i] = 1'b0;
        end
        $display("reset during fetch of 00001040");
        force_ack = 1'b1;
        @(negedge clk); force_ack = 1'b0;
        @(negedge clk);
        chk("t6_stray_ack_en", 256'(mem_enable), 256'(0));
        resp_en = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 32'h40, 32'h0, 1, sc, rd);
        chk("t6_remiss_stall", 256'(sc), 256'(4));
        chk("t6_remiss_data", 256'(rd), 256'(32'hDEAD_BEEF));

        // Store miss merges after refill, seen via later eviction
        access(1'b1, 32'h800, 32'hCAFE_F00D, 2, sc, rd);
        chk("t7_store_miss_stall", 256'(sc), 256'(5));
        access(1'b0, 32'hC00, 32'h0, 1, sc, rd);
        chk("t7_evict_stall", 256'(sc), 256'(7));
        chk("t7_wb_addr", 256'(last_wb_addr), 256'(32'h800));
        chk("t7_wb_word0", 256'(last_wb_data[31:0]), 256'(32'hCAFE_F00D));

        // Store miss abandoned by the CPU: refill completes, no merge
        model_miss(32'h1800, 2, el);
        resp_n = 2;
        p1_req = 1'b1; p1_write = 1'b1; p1_addr = 32'h1800; p1_wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("t8_stall", 256'(p1_stall), 256'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        p1_req = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        $display("store miss to 00001800 dropped mid-refill");
        access(1'b0, 32'h1800, 32'h0, 2, sc, rd);
        chk("t8_hit_stall", 256'(sc), 256'(0));
        chk("t8_not_merged", 256'(rd), 256'(32'h1800 ^ 32'hA5A5_0000));
        access(1'b0, 32'hC00, 32'h0, 1, sc, rd);
        chk("t8_clean_evict_stall", 256'(sc), 256'(4));

        // Random traffic over a few slots and tags
        for (int t = 0; t < 300; t++) begin
            wr = 1'(($urandom_range(0, 1)));
            a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
               | (32'($urandom_range(0, 7)) << 2) | 32'h0001_0000;
            access(wr, a, $urandom, int'($urandom_range(0, 5)), sc, rd);
            if ($urandom_range(0, 3) == 0) begin
                p1_req = 1'b0;
                @(posedge clk); #1;
            end
        end
        p1_req = 1'b0;
        repeat (3) @(posedge clk);
        chk("exp_queue_empty", 256'(exp_q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
